// File: rtl/types_pkg.sv
// Shared datapath types for the operand/mode front end.
package types_pkg;

    typedef logic [15:0] word_t;

    // Operation modes in the order the mode buttons step through them.
    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND_OP,
        OR_OP,
        XOR_OP
    } opr_mode_t;

endpackage

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: synchronises and debounces the board switches and the two mode
// buttons, presenting a stable operand word and the current operation mode.
// Optional feature: define SW_CHANGE_COUNT_EN to add the saturating CHANGE_CNT output.
module sw_input_conditioner
    import types_pkg::*;
#(
    parameter int unsigned BITS            = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] SW_RAW,
    input  logic            BTN_NEXT,
    input  logic            BTN_PREV,
    output logic [BITS-1:0] SW,
    output opr_mode_t       SELECTOR,
    output logic            SW_VALID
`ifdef SW_CHANGE_COUNT_EN
    ,
    output logic [7:0]      CHANGE_CNT
`endif
);

    localparam int unsigned W  = BITS + 2;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Synchroniser chains for {BTN_PREV, BTN_NEXT, SW_RAW}, plus last cycle's synced value.
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_prev_q;

    logic [BITS-1:0] sw_sync, sw_prev;
    logic [1:0]      btn_sync, btn_prev;

    // Switch debounce state
    logic [BITS-1:0] sw_q, sw_d;
    logic [CW-1:0]   sw_cnt_q, sw_cnt_d;
    logic            sw_acc;

    // Button debounce state, index 0 = next, 1 = prev
    logic [1:0]    btn_db_q, btn_db_d, btn_acc;
    logic [CW-1:0] btn_cnt_q [2];
    logic [CW-1:0] btn_cnt_d [2];

    logic      next_rise, prev_rise;
    opr_mode_t sel_q, sel_d;
    logic      valid_q, valid_d;

    assign sw_sync  = sync_q[SYNC_STAGES-1][BITS-1:0];
    assign btn_sync = sync_q[SYNC_STAGES-1][BITS+1:BITS];
    assign sw_prev  = sync_prev_q[BITS-1:0];
    assign btn_prev = sync_prev_q[BITS+1:BITS];

    // Plain flop chain per input bit, then one extra stage for change detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= {BTN_PREV, BTN_NEXT, SW_RAW};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Switch debounce: one shared counter; accept once the candidate has been stable long enough.
    // The accepted value is the one that was counted (last cycle's sync), so a change on the
    // accepting cycle itself cannot slip through unfiltered.
    always_comb begin
        sw_d     = sw_q;
        sw_cnt_d = sw_cnt_q;
        sw_acc   = 1'b0;
        if (sw_cnt_q == CNT_MAX) begin
            sw_d     = sw_prev;
            sw_cnt_d = '0;
            sw_acc   = 1'b1;
        end else if (sw_sync == sw_q) begin
            sw_cnt_d = '0;
        end else if (sw_sync != sw_prev) begin
            sw_cnt_d = CNT_ONE;
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    // Button debounce: same rule as the switches, one counter per button
    always_comb begin
        btn_db_d = btn_db_q;
        btn_acc  = '0;
        for (int b = 0; b < 2; b++) begin
            btn_cnt_d[b] = btn_cnt_q[b];
            if (btn_cnt_q[b] == CNT_MAX) begin
                btn_db_d[b]  = btn_prev[b];
                btn_cnt_d[b] = '0;
                btn_acc[b]   = 1'b1;
            end else if (btn_sync[b] == btn_db_q[b]) begin
                btn_cnt_d[b] = '0;
            end else if (btn_sync[b] != btn_prev[b]) begin
                btn_cnt_d[b] = CNT_ONE;
            end else begin
                btn_cnt_d[b] = btn_cnt_q[b] + CNT_ONE;
            end
        end
    end

    // An acceptance always flips the debounced level, so accepting a 1 is a rising edge
    assign next_rise = btn_acc[0] & btn_prev[0];
    assign prev_rise = btn_acc[1] & btn_prev[1];

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_q         <= '0;
            sw_cnt_q     <= '0;
            btn_db_q     <= '0;
            btn_cnt_q[0] <= '0;
            btn_cnt_q[1] <= '0;
        end else begin
            sw_q         <= sw_d;
            sw_cnt_q     <= sw_cnt_d;
            btn_db_q     <= btn_db_d;
            btn_cnt_q[0] <= btn_cnt_d[0];
            btn_cnt_q[1] <= btn_cnt_d[1];
        end
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q <= ADD;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Mode next-state: opposing presses on the same cycle cancel
    always_comb begin
        sel_d = sel_q;
        if (next_rise && !prev_rise) begin
            sel_d = sel_q.next();
        end else if (prev_rise && !next_rise) begin
            sel_d = sel_q.prev();
        end
    end

    // One pulse per update edge, whether SW, SELECTOR or both moved
    assign valid_d = sw_acc | (sel_d != sel_q);

    // Update strobe register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Outputs straight from registers
    always_comb begin
        SW       = sw_q;
        SELECTOR = sel_q;
        SW_VALID = valid_q;
    end

`ifdef SW_CHANGE_COUNT_EN
    logic [7:0] chg_cnt_q;

    // Saturating count of update pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            chg_cnt_q <= '0;
        end else if (valid_q && (chg_cnt_q != 8'hFF)) begin
            chg_cnt_q <= chg_cnt_q + 8'd1;
        end
    end

    assign CHANGE_CNT = chg_cnt_q;
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench for sw_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference model keeps the raw input history and accepts a new debounced value when the
// last DEBOUNCE_CYCLES synchronised samples all show the same new value.
module tb_sw_input_conditioner;
    import types_pkg::*;

    localparam int BITS = 16;
    localparam int SS   = 2;
    localparam int DC   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [BITS-1:0] SW_RAW = '0;
    logic            BTN_NEXT = 1'b0;
    logic            BTN_PREV = 1'b0;
    logic [BITS-1:0] SW;
    opr_mode_t       SELECTOR;
    logic            SW_VALID;
`ifdef SW_CHANGE_COUNT_EN
    logic [7:0]      CHANGE_CNT;
`endif

    sw_input_conditioner #(
        .BITS            (BITS),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SW_RAW     (SW_RAW),
        .BTN_NEXT   (BTN_NEXT),
        .BTN_PREV   (BTN_PREV),
        .SW         (SW),
        .SELECTOR   (SELECTOR),
        .SW_VALID   (SW_VALID)
`ifdef SW_CHANGE_COUNT_EN
        ,
        .CHANGE_CNT (CHANGE_CNT)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [17:0]     raw_hist[$];  // {prev, next, sw} present before each edge since reset
    int              t;
    logic [BITS-1:0] m_sw;
    logic            m_next, m_prev, m_valid;
    int              m_sel, m_cnt, n_modes;
    int              last_sw, last_n, last_p;

    function automatic logic [15:0] smp(input int k, input int f);
        logic [17:0] v;
        if (k - SS < 0) return 16'h0;
        v = raw_hist[k-SS];
        case (f)
            0:       return v[15:0];
            1:       return {15'b0, v[16]};
            default: return {15'b0, v[17]};
        endcase
    endfunction

    // True when the DC samples before edge tt agree on a value different from cur and
    // all of them arrived after the previous acceptance at edge last.
    function automatic bit stable_run(input int tt, input int f, input logic [15:0] cur,
                                      input int last, output logic [15:0] v);
        v = smp(tt - 1, f);
        if (tt - DC <= last) return 1'b0;
        if (v == cur) return 1'b0;
        for (int k = tt - DC; k < tt; k++) begin
            if (smp(k, f) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        t       = 0;
        m_sw    = '0;
        m_next  = 1'b0;
        m_prev  = 1'b0;
        m_sel   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        last_sw = -1000;
        last_n  = -1000;
        last_p  = -1000;
    endtask

    task automatic model_edge();
        logic [15:0] v;
        bit          sw_chg, nrise, prise;
        if (!rst) begin
            model_reset();
            return;
        end
        raw_hist.push_back({BTN_PREV, BTN_NEXT, SW_RAW});
        if (m_valid && m_cnt < 255) m_cnt++;
        sw_chg = stable_run(t, 0, m_sw, last_sw, v);
        if (sw_chg) begin
            m_sw    = v;
            last_sw = t;
        end
        nrise = 1'b0;
        if (stable_run(t, 1, {15'b0, m_next}, last_n, v)) begin
            m_next = v[0];
            last_n = t;
            nrise  = v[0];
        end
        prise = 1'b0;
        if (stable_run(t, 2, {15'b0, m_prev}, last_p, v)) begin
            m_prev = v[0];
            last_p = t;
            prise  = v[0];
        end
        if (nrise && !prise) m_sel = (m_sel + 1) % n_modes;
        if (prise && !nrise) m_sel = (m_sel + n_modes - 1) % n_modes;
        m_valid = sw_chg || (nrise != prise);
        t++;
    endtask

    // Advance n clocks, checking every output against the model after each edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_eq("sw", SW, m_sw);
            check_eq("sel", SELECTOR, m_sel);
            check_eq("valid", SW_VALID, m_valid);
`ifdef SW_CHANGE_COUNT_EN
            check_eq("cnt", CHANGE_CNT, m_cnt);
`endif
            if (SW_VALID) pulses++;
        end
    endtask

    initial begin
        opr_mode_t tmp;
        tmp     = ADD;
        n_modes = tmp.num();
        model_reset();

        // Reset held with switches all high
        rst    = 1'b0;
        SW_RAW = 16'hFFFF;
        step(3);
        check_eq("rst_sw", SW, 0);
        check_eq("rst_sel", SELECTOR, ADD);
        check_eq("rst_valid", SW_VALID, 0);

        // Basic latency: value appears on edge SYNC_STAGES+DEBOUNCE_CYCLES
        rst    = 1'b1;
        SW_RAW = 16'd5;
        step(6);
        check_eq("lat_early", SW, 0);
        step(1);
        check_eq("lat_sw", SW, 5);
        check_eq("lat_valid", SW_VALID, 1);
        step(1);
        check_eq("lat_valid_drop", SW_VALID, 0);

        // Short glitch must be rejected
        SW_RAW = 16'h0000;
        step(12);
        pulses = 0;
        SW_RAW = 16'h00F0;
        step(3);
        SW_RAW = 16'h0000;
        step(12);
        check_eq("glitch_sw", SW, 0);
        check_eq("glitch_pulses", pulses, 0);

        // Held next button steps once; full lap wraps to ADD
        for (int r = 0; r < n_modes; r++) begin
            pulses   = 0;
            BTN_NEXT = 1'b1;
            step(20);
            BTN_NEXT = 1'b0;
            step(10);
            check_eq("next_step", SELECTOR, (r + 1) % n_modes);
            check_eq("next_pulses", pulses, 1);
        end
        check_eq("next_wrap", SELECTOR, ADD);

        // Simultaneous presses cancel; prev from ADD wraps to last literal
        pulses   = 0;
        BTN_NEXT = 1'b1;
        BTN_PREV = 1'b1;
        step(10);
        BTN_NEXT = 1'b0;
        BTN_PREV = 1'b0;
        step(10);
        check_eq("both_sel", SELECTOR, ADD);
        check_eq("both_pulses", pulses, 0);
        BTN_PREV = 1'b1;
        step(20);
        BTN_PREV = 1'b0;
        step(10);
        check_eq("prev_wrap", SELECTOR, n_modes - 1);

        // Reset in the middle of a debounce discards the pending value
        SW_RAW = 16'hA5A5;
        step(4);
        rst = 1'b0;
        step(1);
        check_eq("mid_rst_sw", SW, 0);
        check_eq("mid_rst_sel", SELECTOR, ADD);
        rst = 1'b1;
        step(6);
        check_eq("mid_rst_early", SW, 0);
        step(1);
        check_eq("mid_rst_sw_after", SW, 16'hA5A5);

        // Randomised stimulus: mostly held levels, short glitches, presses, rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) SW_RAW = 16'($urandom());
            else if ($urandom_range(0, 19) == 0) SW_RAW[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 11) == 0) BTN_NEXT = ~BTN_NEXT;
            if ($urandom_range(0, 11) == 0) BTN_PREV = ~BTN_PREV;
            rst = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst = 1'b1;
        step(2);

`ifdef SW_CHANGE_COUNT_EN
        // Enough forced changes to saturate the counter
        BTN_NEXT = 1'b0;
        BTN_PREV = 1'b0;
        step(10);
        for (int i = 0; i < 300; i++) begin
            SW_RAW = SW ^ 16'h1;
            step(SS + DC + 2);
        end
        check_eq("cnt_sat", CHANGE_CNT, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
